// File: rtl/fft_agu_pkg.sv
// Shared types and address helpers for the runtime-configurable radix-2 DIT FFT address unit.
package fft_agu_pkg;

  localparam int AGU_M   = 9;
  localparam int LOG2N_W = $clog2(AGU_M + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_UNLOAD
  } agu_state_t;

  // Opens a zero at bit position l of the butterfly index: the A operand address.
  function automatic logic [31:0] bit_insert(input logic [31:0] i, input int unsigned l);
    logic [31:0] low_mask;
    low_mask = (32'd1 << l) - 32'd1;
    return ((i >> l) << (l + 1)) | (i & low_mask);
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned len);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < len) r = {r[30:0], k[b]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_agu_cfg_if.sv
// Control, read-issue and write-back bundle of the FFT address unit.
// FFT_AGU_BITREV_EN adds the bit-reversed unload handshake.
interface fft_agu_cfg_if #(
  parameter int M  = 9,
  parameter int LW = $clog2(M + 1)
);
  logic          start;
  logic [LW-1:0] log2n;
  logic          enable;
  logic          busy;
  logic          done;
  logic          rd_valid;
  logic          rd_sel;
  logic [M-1:0]  adr_A;
  logic [M-1:0]  adr_B;
  logic [M-2:0]  twiddle_adr;
  logic          we0;
  logic          we1;
  logic [M-1:0]  wr_adr_A;
  logic [M-1:0]  wr_adr_B;
  logic          result_bank;
`ifdef FFT_AGU_BITREV_EN
  logic          unload_valid;
  logic          unload_ready;
  logic [M-1:0]  unload_adr;
`endif

  modport master (
`ifdef FFT_AGU_BITREV_EN
    output unload_ready,
    input  unload_valid, unload_adr,
`endif
    output start, log2n, enable,
    input  busy, done, rd_valid, rd_sel, adr_A, adr_B, twiddle_adr,
    input  we0, we1, wr_adr_A, wr_adr_B, result_bank
  );

  modport slave (
`ifdef FFT_AGU_BITREV_EN
    input  unload_ready,
    output unload_valid, unload_adr,
`endif
    input  start, log2n, enable,
    output busy, done, rd_valid, rd_sel, adr_A, adr_B, twiddle_adr,
    output we0, we1, wr_adr_A, wr_adr_B, result_bank
  );
endinterface

// File: rtl/fft_agu_wr_delay.sv
// Fixed-depth shift register aligning write-back addresses with the butterfly pipeline.
module fft_agu_wr_delay #(
  parameter int W     = 20,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [W-1:0] q_reg;
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= din;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (reset) q_reg <= '0;
        else       q_reg <= g_stage[gi-1].q_reg;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/fft_agu_cfg.sv
// Runtime-sized in-place radix-2 DIT FFT address generator with ping-pong banks.
// FFT_AGU_BITREV_EN adds a bit-reversed unload phase before completion.
module fft_agu_cfg
  import fft_agu_pkg::*;
#(
  parameter int M        = 9,
  parameter int BFLY_LAT = 3
) (
  input logic          clk,
  input logic          reset,
  fft_agu_cfg_if.slave agu
);

  localparam int LW = $clog2(M + 1);
  localparam int DW = $clog2(BFLY_LAT + 1);

  agu_state_t    state_reg, state_next;
  logic [LW-1:0] len_reg, len_next;
  logic [LW-1:0] lvl_reg, lvl_next;
  logic [M-1:0]  idx_reg, idx_next;
  logic [DW-1:0] drain_reg, drain_next;
  logic          bank_reg, bank_next;
  logic          issue;

  logic [M-1:0]  lvl_bit, low_mask, a_addr, b_addr, half_last;
  logic [M-2:0]  tw_addr;

  always_comb begin
    lvl_bit   = M'(32'd1 << lvl_reg);
    low_mask  = lvl_bit - 1'b1;
    a_addr    = M'(bit_insert(32'(idx_reg), 32'(lvl_reg)));
    b_addr    = a_addr | lvl_bit;
    // Twiddle stride is set by the maximum table size, so the ROM never depends on L.
    tw_addr   = (M-1)'((idx_reg & low_mask) << (32'(M - 1) - 32'(lvl_reg)));
    half_last = M'((32'd1 << (32'(len_reg) - 32'd1)) - 32'd1);
  end

`ifdef FFT_AGU_BITREV_EN
  logic [M-1:0] k_reg, k_next, full_last;
  assign full_last = M'((32'd1 << len_reg) - 32'd1);
`endif

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    lvl_next   = lvl_reg;
    idx_next   = idx_reg;
    drain_next = drain_reg;
    bank_next  = bank_reg;
    issue      = 1'b0;
`ifdef FFT_AGU_BITREV_EN
    k_next     = k_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (agu.start) begin
          if (agu.log2n == '0 || agu.log2n > LW'(M)) len_next = LW'(M);
          else                                       len_next = agu.log2n;
          bank_next  = len_next[0];
          lvl_next   = '0;
          idx_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (agu.enable) begin
          issue = 1'b1;
          if (idx_reg == half_last) begin
            idx_next   = '0;
            drain_next = '0;
            state_next = S_DRAIN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_reg == DW'(BFLY_LAT - 1)) begin
          if (lvl_reg == len_reg - 1'b1) begin
`ifdef FFT_AGU_BITREV_EN
            k_next     = '0;
            state_next = S_UNLOAD;
`else
            state_next = S_DONE;
`endif
          end else begin
            lvl_next   = lvl_reg + 1'b1;
            state_next = S_RUN;
          end
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
`ifdef FFT_AGU_BITREV_EN
      S_UNLOAD: begin
        if (agu.unload_ready) begin
          if (k_reg == full_last) state_next = S_DONE;
          else                    k_next     = k_reg + 1'b1;
        end
      end
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      lvl_reg   <= '0;
      idx_reg   <= '0;
      drain_reg <= '0;
      bank_reg  <= 1'b0;
`ifdef FFT_AGU_BITREV_EN
      k_reg     <= '0;
`endif
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      lvl_reg   <= lvl_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
      bank_reg  <= bank_next;
`ifdef FFT_AGU_BITREV_EN
      k_reg     <= k_next;
`endif
    end
  end

  assign agu.busy        = (state_reg != S_IDLE);
  assign agu.done        = (state_reg == S_DONE);
  assign agu.result_bank = bank_reg;
  assign agu.rd_valid    = issue;
  assign agu.rd_sel      = issue & lvl_reg[0];
  assign agu.adr_A       = issue ? a_addr  : '0;
  assign agu.adr_B       = issue ? b_addr  : '0;
  assign agu.twiddle_adr = issue ? tw_addr : '0;

  logic         wr_valid, wr_sel;
  logic [M-1:0] wr_a, wr_b;

  fft_agu_wr_delay #(
    .W     (2 * M + 2),
    .DEPTH (BFLY_LAT)
  ) u_wr_delay (
    .clk   (clk),
    .reset (reset),
    .din   ({agu.rd_valid, agu.rd_sel, agu.adr_A, agu.adr_B}),
    .dout  ({wr_valid, wr_sel, wr_a, wr_b})
  );

  // Each level writes back into the bank opposite the one it read.
  assign agu.we1      = wr_valid & ~wr_sel;
  assign agu.we0      = wr_valid &  wr_sel;
  assign agu.wr_adr_A = wr_a;
  assign agu.wr_adr_B = wr_b;

`ifdef FFT_AGU_BITREV_EN
  logic [M-1:0] rev_k;
  assign rev_k            = M'(bitrev(32'(k_reg), 32'(len_reg)));
  assign agu.unload_valid = (state_reg == S_UNLOAD);
  assign agu.unload_adr   = agu.unload_valid ? rev_k : '0;
`endif

endmodule
